// File: rtl/vex_uop_sequencer_if.sv
// Bundle between the vector issue queue, the uop sequencer and the lane array.
// Signal suffixes are from the sequencer's point of view.
//
// Handshakes:
//   instr: an instruction transfers on a rising clk edge where instr_valid_i
//          and instr_ready_o are both high. instr_ready_o does not depend on
//          instr_valid_i.
//   lane : a uop transfers on a rising clk edge where lane_valid_o is high.
//          lane_valid_o is only raised when every bit of lane_ready_i is high.
//          While the lanes stall, uop_idx_o and the payload outputs hold.
interface vex_uop_sequencer_if #(
  parameter int VECTOR_LANES = 8,
  parameter int VL_W         = 7,
  parameter int UIDX_W       = $clog2((2**VL_W + VECTOR_LANES - 1) / VECTOR_LANES)
);
  logic                    instr_valid_i;
  logic                    instr_ready_o;
  logic [5:0]              instr_funct6_i;
  logic [2:0]              instr_funct3_i;
  logic [VL_W-1:0]         instr_vl_i;
  logic                    instr_vm_i;
  logic                    instr_is_rdc_i;
  logic [VECTOR_LANES-1:0] vmask_i;
  logic [VECTOR_LANES-1:0] lane_ready_i;
  logic                    lane_valid_o;
  logic [VECTOR_LANES-1:0] lane_mask_o;
  logic [UIDX_W-1:0]       uop_idx_o;
  logic [5:0]              funct6_o;
  logic [2:0]              funct3_o;
  logic [VL_W-1:0]         vl_o;
  logic                    is_rdc_o;
  logic                    head_uop_ex3_o;
  logic                    end_uop_ex3_o;
  logic                    done_o;
  logic                    busy_o;
  logic [1:0]              state_dbg_o;

  // Sequencer side.
  modport slave (
    input  instr_valid_i, instr_funct6_i, instr_funct3_i, instr_vl_i,
           instr_vm_i, instr_is_rdc_i, vmask_i, lane_ready_i,
    output instr_ready_o, lane_valid_o, lane_mask_o, uop_idx_o, funct6_o,
           funct3_o, vl_o, is_rdc_o, head_uop_ex3_o, end_uop_ex3_o, done_o,
           busy_o, state_dbg_o
  );

  // Issue queue / lane array side.
  modport master (
    output instr_valid_i, instr_funct6_i, instr_funct3_i, instr_vl_i,
           instr_vm_i, instr_is_rdc_i, vmask_i, lane_ready_i,
    input  instr_ready_o, lane_valid_o, lane_mask_o, uop_idx_o, funct6_o,
           funct3_o, vl_o, is_rdc_o, head_uop_ex3_o, end_uop_ex3_o, done_o,
           busy_o, state_dbg_o
  );
endinterface

// File: rtl/vex_uop_sequencer.sv
// Vector uop sequencer: splits one vector instruction into ceil(vl/VECTOR_LANES)
// uops, issues them to the lane array with per-lane element masks, tracks the
// head/end uops into EX3 and pulses done_o once the last uop has written back.
module vex_uop_sequencer #(
  parameter int VECTOR_LANES = 8,
  parameter int VL_W         = 7,
  parameter int PIPE_DEPTH   = 4,
  parameter int EX3_DELAY    = 2,
  parameter int UIDX_W       = $clog2((2**VL_W + VECTOR_LANES - 1) / VECTOR_LANES)
) (
  input  logic                clk,
  input  logic                rst_n,
  vex_uop_sequencer_if.slave  bus
);

  localparam int LANE_W = $clog2(VECTOR_LANES);
  // Element index width with one spare bit so uop_idx*LANES+k never wraps.
  localparam int EW     = UIDX_W + LANE_W + 1;
  localparam int CW     = (EW > VL_W) ? EW : VL_W;
  localparam int CNT_W  = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [UIDX_W-1:0]       uop_idx_q, uop_idx_d;
  logic [UIDX_W-1:0]       last_idx_q, last_idx_d;   // nuops - 1
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [5:0]              funct6_q, funct6_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [VL_W-1:0]         vl_q, vl_d;
  logic                    vm_q, vm_d;
  logic                    is_rdc_q, is_rdc_d;
  logic [EX3_DELAY-1:0]    sv_q, sv_d;               // stage valid (fire)
  logic [EX3_DELAY-1:0]    sh_q, sh_d;               // stage head flag
  logic [EX3_DELAY-1:0]    se_q, se_d;               // stage end flag

  logic                    fire;
  logic                    is_head;
  logic                    is_last;
  logic [VECTOR_LANES-1:0] mask;

  assign fire    = (state_q == ST_ISSUE) && (&bus.lane_ready_i);
  assign is_head = (uop_idx_q == '0);
  assign is_last = (uop_idx_q == last_idx_q);

  // Per-lane element mask: element in range of vl and enabled by v0 unless unmasked.
  always_comb begin
    mask = '0;
    for (int k = 0; k < VECTOR_LANES; k++) begin
      mask[k] = ((CW'(uop_idx_q) * CW'(VECTOR_LANES) + CW'(k)) < CW'(vl_q)) &&
                (vm_q || bus.vmask_i[k]);
    end
  end

  // Next-state logic: accept in IDLE, step uops in ISSUE, count down in DRAIN.
  always_comb begin
    state_d    = state_q;
    uop_idx_d  = uop_idx_q;
    last_idx_d = last_idx_q;
    cnt_d      = cnt_q;
    funct6_d   = funct6_q;
    funct3_d   = funct3_q;
    vl_d       = vl_q;
    vm_d       = vm_q;
    is_rdc_d   = is_rdc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid_i) begin
          funct6_d  = bus.instr_funct6_i;
          funct3_d  = bus.instr_funct3_i;
          vl_d      = bus.instr_vl_i;
          vm_d      = bus.instr_vm_i;
          is_rdc_d  = bus.instr_is_rdc_i;
          uop_idx_d = '0;
          if (bus.instr_vl_i == '0) begin
            // Empty instruction: no uops, complete on the next cycle.
            last_idx_d = '0;
            cnt_d      = '0;
            state_d    = ST_DRAIN;
          end else begin
            last_idx_d = UIDX_W'((bus.instr_vl_i - VL_W'(1)) / VL_W'(VECTOR_LANES));
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (fire) begin
          if (is_last) begin
            cnt_d   = CNT_W'(PIPE_DEPTH - 1);
            state_d = ST_DRAIN;
          end else begin
            uop_idx_d = uop_idx_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // EX3 tracking: shift {fire, head, end} one stage per cycle.
  always_comb begin
    sv_d = (sv_q << 1) | EX3_DELAY'(fire);
    sh_d = (sh_q << 1) | EX3_DELAY'(is_head);
    se_d = (se_q << 1) | EX3_DELAY'(is_last);
  end

  // State and datapath registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      uop_idx_q  <= '0;
      last_idx_q <= '0;
      cnt_q      <= '0;
      funct6_q   <= '0;
      funct3_q   <= '0;
      vl_q       <= '0;
      vm_q       <= 1'b0;
      is_rdc_q   <= 1'b0;
      sv_q       <= '0;
      sh_q       <= '0;
      se_q       <= '0;
    end else begin
      state_q    <= state_d;
      uop_idx_q  <= uop_idx_d;
      last_idx_q <= last_idx_d;
      cnt_q      <= cnt_d;
      funct6_q   <= funct6_d;
      funct3_q   <= funct3_d;
      vl_q       <= vl_d;
      vm_q       <= vm_d;
      is_rdc_q   <= is_rdc_d;
      sv_q       <= sv_d;
      sh_q       <= sh_d;
      se_q       <= se_d;
    end
  end

  assign bus.instr_ready_o  = (state_q == ST_IDLE);
  assign bus.busy_o         = (state_q != ST_IDLE);
  assign bus.lane_valid_o   = fire;
  assign bus.lane_mask_o    = (state_q == ST_ISSUE) ? mask : '0;
  assign bus.uop_idx_o      = uop_idx_q;
  assign bus.funct6_o       = funct6_q;
  assign bus.funct3_o       = funct3_q;
  assign bus.vl_o           = vl_q;
  assign bus.is_rdc_o       = is_rdc_q;
  assign bus.done_o         = (state_q == ST_DRAIN) && (cnt_q == '0);
  assign bus.head_uop_ex3_o = sv_q[EX3_DELAY-1] & sh_q[EX3_DELAY-1];
  assign bus.end_uop_ex3_o  = sv_q[EX3_DELAY-1] & se_q[EX3_DELAY-1];
  assign bus.state_dbg_o    = state_q;

endmodule

// File: tb/tb_vex_uop_sequencer.sv
// Bench for vex_uop_sequencer: a timeline model of the instruction in flight
// checked every negedge, plus hand-computed cycle/mask expectations per vector.
module tb_vex_uop_sequencer;

  localparam int L      = 8;
  localparam int VL_W   = 7;
  localparam int PD     = 4;
  localparam int EXD    = 2;
  localparam int UIDX_W = $clog2((2**VL_W + L - 1) / L);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vex_uop_sequencer_if #(.VECTOR_LANES(L), .VL_W(VL_W), .UIDX_W(UIDX_W)) bus ();

  vex_uop_sequencer #(
    .VECTOR_LANES(L), .VL_W(VL_W), .PIPE_DEPTH(PD), .EX3_DELAY(EXD), .UIDX_W(UIDX_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- counters / logs ----------------
  int n_vec = 0;
  int n_err = 0;

  int           v_cyc_q[$];
  int           v_idx_q[$];
  logic [L-1:0] v_mask_q[$];
  int           head_q[$];
  int           end_q[$];
  int           done_q[$];
  logic [23:0]  exp_q[$];   // {issue offset, uop idx, mask}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    v_cyc_q.delete(); v_idx_q.delete(); v_mask_q.delete();
    head_q.delete(); end_q.delete(); done_q.delete(); exp_q.delete();
  endtask

  // ---------------- timeline model ----------------
  bit           m_busy = 1'b0;
  int           m_vl, m_nuops, m_issued, m_done_at;
  bit           m_vm, m_rdc;
  logic [5:0]   m_f6;
  logic [2:0]   m_f3;
  bit           head_ev[int];
  bit           end_ev[int];
  bit           issuing, exp_fire, exp_done;
  logic [L-1:0] exp_mask;

  // Compare every cycle, log events, then advance the model over the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      head_ev.delete();
      end_ev.delete();
      chk("rst_ready", bus.instr_ready_o, 1);
      chk("rst_busy",  bus.busy_o, 0);
      chk("rst_valid", bus.lane_valid_o, 0);
      chk("rst_done",  bus.done_o, 0);
      chk("rst_head",  bus.head_uop_ex3_o, 0);
      chk("rst_end",   bus.end_uop_ex3_o, 0);
      chk("rst_mask",  bus.lane_mask_o, 0);
      chk("rst_idx",   bus.uop_idx_o, 0);
      chk("rst_f6",    bus.funct6_o, 0);
      chk("rst_vl",    bus.vl_o, 0);
      chk("rst_rdc",   bus.is_rdc_o, 0);
    end else begin
      issuing  = m_busy && (m_issued < m_nuops);
      exp_fire = issuing && (&bus.lane_ready_i);
      exp_done = m_busy && (cyc == m_done_at);
      exp_mask = '0;
      for (int k = 0; k < L; k++)
        exp_mask[k] = issuing && (m_issued * L + k < m_vl) && (m_vm || bus.vmask_i[k]);

      chk("ready", bus.instr_ready_o, !m_busy);
      chk("busy",  bus.busy_o, m_busy);
      chk("valid", bus.lane_valid_o, exp_fire);
      chk("done",  bus.done_o, exp_done);
      chk("head",  bus.head_uop_ex3_o, head_ev.exists(cyc));
      chk("end",   bus.end_uop_ex3_o, end_ev.exists(cyc));
      if (issuing) begin
        chk("mask", bus.lane_mask_o, exp_mask);
        chk("idx",  bus.uop_idx_o, m_issued);
      end
      if (m_busy) begin
        chk("f6",  bus.funct6_o, m_f6);
        chk("f3",  bus.funct3_o, m_f3);
        chk("vl",  bus.vl_o, m_vl);
        chk("rdc", bus.is_rdc_o, m_rdc);
      end

      if (bus.lane_valid_o) begin
        v_cyc_q.push_back(cyc);
        v_idx_q.push_back(int'(bus.uop_idx_o));
        v_mask_q.push_back(bus.lane_mask_o);
      end
      if (bus.head_uop_ex3_o) head_q.push_back(cyc);
      if (bus.end_uop_ex3_o)  end_q.push_back(cyc);
      if (bus.done_o)         done_q.push_back(cyc);

      if (!m_busy) begin
        if (bus.instr_valid_i) begin
          m_busy    = 1'b1;
          m_f6      = bus.instr_funct6_i;
          m_f3      = bus.instr_funct3_i;
          m_vl      = int'(bus.instr_vl_i);
          m_vm      = bus.instr_vm_i;
          m_rdc     = bus.instr_is_rdc_i;
          m_nuops   = (m_vl + L - 1) / L;
          m_issued  = 0;
          m_done_at = (m_vl == 0) ? cyc + 1 : -1;
        end
      end else if (exp_done) begin
        m_busy = 1'b0;
      end else if (exp_fire) begin
        if (m_issued == 0) head_ev[cyc + EXD] = 1'b1;
        if (m_issued == m_nuops - 1) begin
          end_ev[cyc + EXD] = 1'b1;
          m_done_at = cyc + PD;
        end
        m_issued++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic go_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [5:0] f6, input logic [2:0] f3, input int vl,
                      input bit vm, input bit rdc, output int acc);
    @(posedge clk); #1;
    bus.instr_valid_i  = 1'b1;
    bus.instr_funct6_i = f6;
    bus.instr_funct3_i = f3;
    bus.instr_vl_i     = VL_W'(vl);
    bus.instr_vm_i     = vm;
    bus.instr_is_rdc_i = rdc;
    acc = cyc;
    @(posedge clk); #1;
    bus.instr_valid_i  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.instr_ready_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_idle"}, bus.instr_ready_o, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Compare the logged issues against the hand-computed list in exp_q.
  task automatic check_issues(input string name, input int acc);
    logic [23:0] e;
    chk({name, "_nissue"}, v_cyc_q.size(), exp_q.size());
    for (int i = 0; i < v_cyc_q.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      chk({name, "_off"},  v_cyc_q[i] - acc, e[23:16]);
      chk({name, "_uidx"}, v_idx_q[i], e[15:8]);
      chk({name, "_lmask"}, v_mask_q[i], e[7:0]);
    end
    exp_q.delete();
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    int acc;
    bus.instr_valid_i  = 1'b0;
    bus.instr_funct6_i = '0;
    bus.instr_funct3_i = '0;
    bus.instr_vl_i     = '0;
    bus.instr_vm_i     = 1'b1;
    bus.instr_is_rdc_i = 1'b0;
    bus.vmask_i        = '0;
    bus.lane_ready_i   = '1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_ready", bus.instr_ready_o, 1);
    chk("post_rst_state", bus.state_dbg_o, 0);

    // 1: vl=20 unmasked -> three uops, last one partial.
    clear_logs();
    bus.vmask_i = 8'h3C;
    send(6'h02, 3'h0, 20, 1'b1, 1'b0, acc);
    go_cycle(acc + 7);
    chk("t1_ready_c7", bus.instr_ready_o, 0);
    go_cycle(acc + 8);
    chk("t1_ready_c8", bus.instr_ready_o, 1);
    wait_idle("t1");
    exp_q.push_back({8'd1, 8'd0, 8'hFF});
    exp_q.push_back({8'd2, 8'd1, 8'hFF});
    exp_q.push_back({8'd3, 8'd2, 8'h0F});
    check_issues("t1", acc);
    chk("t1_head", (head_q.size() == 1) ? head_q[0] - acc : -1, 3);
    chk("t1_end",  (end_q.size()  == 1) ? end_q[0]  - acc : -1, 5);
    chk("t1_done", (done_q.size() == 1) ? done_q[0] - acc : -1, 7);

    // 2: vl=0 -> no uop, done the next cycle.
    clear_logs();
    send(6'h00, 3'h0, 0, 1'b1, 1'b0, acc);
    chk("t2_ready_c1", bus.instr_ready_o, 0);
    go_cycle(acc + 2);
    chk("t2_ready_c2", bus.instr_ready_o, 1);
    wait_idle("t2");
    check_issues("t2", acc);
    chk("t2_done", (done_q.size() == 1) ? done_q[0] - acc : -1, 1);
    chk("t2_nhead", head_q.size(), 0);

    // 3: vl=16 with lane 3 stalled for two cycles; a stray instr_valid is ignored.
    clear_logs();
    send(6'h09, 3'h1, 16, 1'b1, 1'b0, acc);
    go_cycle(acc + 2);
    bus.lane_ready_i   = 8'hF7;
    bus.instr_valid_i  = 1'b1;
    bus.instr_funct6_i = 6'h3F;
    bus.instr_vl_i     = VL_W'(3);
    go_cycle(acc + 3);
    chk("t3_hold_idx", bus.uop_idx_o, 1);
    bus.instr_valid_i  = 1'b0;
    go_cycle(acc + 4);
    bus.lane_ready_i   = '1;
    wait_idle("t3");
    exp_q.push_back({8'd1, 8'd0, 8'hFF});
    exp_q.push_back({8'd4, 8'd1, 8'hFF});
    check_issues("t3", acc);
    chk("t3_head", (head_q.size() == 1) ? head_q[0] - acc : -1, 3);
    chk("t3_end",  (end_q.size()  == 1) ? end_q[0]  - acc : -1, 6);
    chk("t3_done", (done_q.size() == 1) ? done_q[0] - acc : -1, 8);

    // 4: vl=8 masked by v0=0xAA -> single uop, head and end together.
    clear_logs();
    bus.vmask_i = 8'hAA;
    send(6'h00, 3'h0, 8, 1'b0, 1'b0, acc);
    wait_idle("t4");
    exp_q.push_back({8'd1, 8'd0, 8'hAA});
    check_issues("t4", acc);
    chk("t4_head", (head_q.size() == 1) ? head_q[0] - acc : -1, 3);
    chk("t4_end",  (end_q.size()  == 1) ? end_q[0]  - acc : -1, 3);
    chk("t4_done", (done_q.size() == 1) ? done_q[0] - acc : -1, 5);

    // 5: vredsum.vs, vl=5 -> mask 0x1F, fields held through done.
    clear_logs();
    bus.vmask_i = 8'h00;
    send(6'h00, 3'h2, 5, 1'b1, 1'b1, acc);
    go_cycle(acc + 5);
    chk("t5_rdc_at_done", bus.is_rdc_o, 1);
    chk("t5_f3_at_done",  bus.funct3_o, 3'h2);
    chk("t5_vl_at_done",  bus.vl_o, 5);
    chk("t5_done_now",    bus.done_o, 1);
    wait_idle("t5");
    exp_q.push_back({8'd1, 8'd0, 8'h1F});
    check_issues("t5", acc);
    chk("t5_head", (head_q.size() == 1) ? head_q[0] - acc : -1, 3);
    chk("t5_end",  (end_q.size()  == 1) ? end_q[0]  - acc : -1, 3);

    // 6: reset while issuing uop 1 of a 5-uop instruction.
    clear_logs();
    bus.vmask_i = 8'hFF;
    send(6'h05, 3'h3, 40, 1'b1, 1'b0, acc);
    go_cycle(acc + 2);
    chk("t6_pre_idx",  bus.uop_idx_o, 1);
    chk("t6_pre_busy", bus.busy_o, 1);
    clear_logs();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus.lane_valid_o, 0);
    chk("t6_rst_busy",  bus.busy_o, 0);
    chk("t6_rst_ready", bus.instr_ready_o, 1);
    chk("t6_rst_idx",   bus.uop_idx_o, 0);
    go_cycle(acc + 4);
    rst_n = 1'b1;
    go_cycle(acc + 14);
    chk("t6_ndone", done_q.size(), 0);
    chk("t6_nhead", head_q.size(), 0);
    chk("t6_nend",  end_q.size(), 0);
    chk("t6_nissue", v_cyc_q.size(), 0);
    chk("t6_ready", bus.instr_ready_o, 1);
    chk("t6_busy",  bus.busy_o, 0);

    // 7: clean instruction after the abort, vl=9 -> FF then 01.
    clear_logs();
    send(6'h0A, 3'h4, 9, 1'b1, 1'b0, acc);
    wait_idle("t7");
    exp_q.push_back({8'd1, 8'd0, 8'hFF});
    exp_q.push_back({8'd2, 8'd1, 8'h01});
    check_issues("t7", acc);
    chk("t7_done", (done_q.size() == 1) ? done_q[0] - acc : -1, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
